// File: rtl/nx_fifo_mc_pkg.sv
// nx_fifo_mc_pkg -- shared types and helpers for the multi-channel FIFO.
//
// Contents:
//   clog2_min1   : ceil(log2(n)) but never below 1, so a 1-channel build
//                  still has a 1-bit channel index.
//   ch_status_t  : per-channel status bundle {empty, full, almost_full, count}.
//   even_parity  : even-parity bit over a data word (zero-extended input).
//
// Optional feature macro used by the files importing this package:
//   NX_FIFO_MC_PARITY_EN
package nx_fifo_mc_pkg;

  // Count field width inside the status struct. Wide enough for any
  // practical DEPTH; each user slices the low bits it needs.
  localparam int COUNT_W = 16;

  // Widest data word the parity helper accepts. Narrower words are
  // zero-extended, which does not change the XOR reduction.
  localparam int PAR_MAX_W = 1024;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic               empty;
    logic               full;
    logic               almost_full;
    logic [COUNT_W-1:0] count;
  } ch_status_t;

  // Bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nx_fifo_mc_if.sv
// nx_fifo_mc_if -- write/read bus of the multi-channel FIFO.
//
// Signals:
//   wen, wch, wdata : write request, target channel, data
//   ren, rch        : pop request, channel being read / observed
//   rdata           : head entry of channel rch (0 when that channel is empty)
//   inj_perr        : (NX_FIFO_MC_PARITY_EN only) flip stored parity on write
//   rdata_perr      : (NX_FIFO_MC_PARITY_EN only) head entry fails parity
//
// Modports: master drives requests, slave (the FIFO) returns read data.
interface nx_fifo_mc_if #(
  parameter int CW    = 2,
  parameter int WIDTH = 64
);
  logic             wen;
  logic [CW-1:0]    wch;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [CW-1:0]    rch;
  logic [WIDTH-1:0] rdata;
`ifdef NX_FIFO_MC_PARITY_EN
  logic             inj_perr;
  logic             rdata_perr;

  modport master (
    output wen, wch, wdata, ren, rch, inj_perr,
    input  rdata, rdata_perr
  );

  modport slave (
    input  wen, wch, wdata, ren, rch, inj_perr,
    output rdata, rdata_perr
  );
`else
  modport master (
    output wen, wch, wdata, ren, rch,
    input  rdata
  );

  modport slave (
    input  wen, wch, wdata, ren, rch,
    output rdata
  );
`endif
endinterface

// File: rtl/nx_fifo_mc_ctrl.sv
// nx_fifo_mc_ctrl -- pointer/occupancy controller for one FIFO channel.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   clear           : flush this channel (wins over wr_req/rd_req)
//   wr_req, rd_req  : raw write / pop requests already steered to this channel
//   push, pop       : qualified operations the storage must perform this cycle
//   ovf_req,unf_req : rejected write (full) / rejected pop (empty) this cycle
//   wptr, rptr      : write / read pointers into this channel's partition
//   status          : {empty, full, almost_full, count} from the registered count
module nx_fifo_mc_ctrl
  import nx_fifo_mc_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_req,
  input  logic                     rd_req,
  output logic                     push,
  output logic                     pop,
  output logic                     ovf_req,
  output logic                     unf_req,
  output logic [$clog2(DEPTH)-1:0] wptr,
  output logic [$clog2(DEPTH)-1:0] rptr,
  output ch_status_t               status
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH + 1);

  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [UW-1:0] count_reg;

  logic is_empty;
  logic is_full;
  logic wr_live;
  logic rd_live;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == UW'(DEPTH));

  // Requests arriving during reset or together with a clear are dropped
  // without any under/overflow indication.
  assign wr_live = rst_n && wr_req && !clear;
  assign rd_live = rst_n && rd_req && !clear;

  // Decisions use the count at the start of the cycle, so a write to a full
  // channel is rejected even if a pop frees a slot in the same cycle, and a
  // pop on an empty channel never bypasses a simultaneous write.
  assign push    = wr_live && !is_full;
  assign pop     = rd_live && !is_empty;
  assign ovf_req = wr_live && is_full;
  assign unf_req = rd_live && is_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push) wptr_reg <= wptr_reg + PW'(1);
      if (pop)  rptr_reg <= rptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + UW'(1);
        2'b01:   count_reg <= count_reg - UW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign wptr = wptr_reg;
  assign rptr = rptr_reg;

  assign status.empty       = is_empty;
  assign status.full        = is_full;
  assign status.almost_full = (count_reg >= UW'(AFULL_LVL));
  assign status.count       = COUNT_W'(count_reg);

endmodule

// File: rtl/nx_fifo_mc.sv
// nx_fifo_mc -- multi-channel synchronous FIFO with shared storage.
//
// N_CH independent queues of DEPTH entries each live in one storage array,
// channel c owning entries [c*DEPTH, c*DEPTH+DEPTH). Reads are
// first-word-fall-through: rdata shows the head of channel rch
// combinationally; a pop takes effect at the clock edge where ren=1.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : nx_fifo_mc_if.slave (wen/wch/wdata, ren/rch, rdata
//                  and, with parity, inj_perr/rdata_perr)
//   clear        : per-channel flush, priority over same-channel requests
//   empty, full  : per-channel status
//   almost_full  : per-channel used >= AFULL_LVL
//   used_slots   : per-channel occupancy, channel c at [c*UW +: UW]
//   underflow    : 1-cycle pulse, the cycle after a pop on an empty channel
//   overflow     : 1-cycle pulse, the cycle after a write to a full channel
//
// Optional feature macro: NX_FIFO_MC_PARITY_EN -- stores an even-parity bit
// per entry, reports a bad head entry on rdata_perr, and lets inj_perr
// corrupt the stored parity for test.
module nx_fifo_mc
  import nx_fifo_mc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 64,
  parameter int AFULL_LVL  = 6,
  parameter int DATA_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  nx_fifo_mc_if.slave                       bus,
  input  logic [N_CH-1:0]                   clear,
  output logic [N_CH-1:0]                   empty,
  output logic [N_CH-1:0]                   full,
  output logic [N_CH-1:0]                   almost_full,
  output logic [N_CH*$clog2(DEPTH+1)-1:0]   used_slots,
  output logic                              underflow,
  output logic                              overflow
);

  localparam int CW = clog2_min1(N_CH);
  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH + 1);
  localparam int AW = CW + PW;
  localparam int MEM_N = N_CH * DEPTH;
`ifdef NX_FIFO_MC_PARITY_EN
  localparam int EW = WIDTH + 1;  // parity bit sits above the data
`else
  localparam int EW = WIDTH;
`endif

  // ---------------------------------------------------------------------
  // Per-channel controllers
  // ---------------------------------------------------------------------
  logic [N_CH-1:0] wr_req_v;
  logic [N_CH-1:0] rd_req_v;
  logic [N_CH-1:0] push_v;
  logic [N_CH-1:0] pop_v;
  logic [N_CH-1:0] ovf_v;
  logic [N_CH-1:0] unf_v;
  logic [PW-1:0]   wptr_arr [N_CH];
  logic [PW-1:0]   rptr_arr [N_CH];
  ch_status_t      st       [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      // An out-of-range channel index matches no controller, so the request
      // is ignored without flags.
      assign wr_req_v[gi] = bus.wen && (bus.wch == CW'(gi));
      assign rd_req_v[gi] = bus.ren && (bus.rch == CW'(gi));

      nx_fifo_mc_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
      ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear[gi]),
        .wr_req  (wr_req_v[gi]),
        .rd_req  (rd_req_v[gi]),
        .push    (push_v[gi]),
        .pop     (pop_v[gi]),
        .ovf_req (ovf_v[gi]),
        .unf_req (unf_v[gi]),
        .wptr    (wptr_arr[gi]),
        .rptr    (rptr_arr[gi]),
        .status  (st[gi])
      );

      assign empty[gi]             = st[gi].empty;
      assign full[gi]              = st[gi].full;
      assign almost_full[gi]       = st[gi].almost_full;
      assign used_slots[gi*UW +: UW] = st[gi].count[UW-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [EW-1:0] mem [MEM_N];

  logic [PW-1:0] wptr_sel;
  logic [PW-1:0] rptr_sel;
  logic          rd_valid;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          mem_we;
  logic [EW-1:0] wentry;
  logic [EW-1:0] head;

  // Pointer select by channel. DEPTH is a power of two, so the flat
  // address is just {channel, pointer}.
  always_comb begin
    wptr_sel = '0;
    rptr_sel = '0;
    rd_valid = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.wch == CW'(c)) wptr_sel = wptr_arr[c];
      if (bus.rch == CW'(c)) begin
        rptr_sel = rptr_arr[c];
        rd_valid = !st[c].empty;
      end
    end
  end

  assign waddr = {bus.wch, wptr_sel};
  assign raddr = {bus.rch, rptr_sel};

  // Only the channel addressed by wch can push, so any push means a write.
  assign mem_we = |push_v;

`ifdef NX_FIFO_MC_PARITY_EN
  assign wentry = {even_parity(PAR_MAX_W'(bus.wdata)) ^ bus.inj_perr, bus.wdata};
`else
  assign wentry = bus.wdata;
`endif

  generate
    if (DATA_RESET != 0) begin : g_mem_rst
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
        end else if (mem_we) begin
          mem[waddr] <= wentry;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (mem_we) mem[waddr] <= wentry;
      end
    end
  endgenerate

  // First-word-fall-through read. An empty or out-of-range channel reads 0;
  // rd_valid is never set for an out-of-range rch, so raddr is never used then.
  assign head      = mem[raddr];
  assign bus.rdata = rd_valid ? head[WIDTH-1:0] : '0;

`ifdef NX_FIFO_MC_PARITY_EN
  assign bus.rdata_perr = rd_valid &&
                          (head[WIDTH] != even_parity(PAR_MAX_W'(head[WIDTH-1:0])));
`endif

  // ---------------------------------------------------------------------
  // Error pulses, one cycle after the rejected request
  // ---------------------------------------------------------------------
  logic underflow_reg;
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      underflow_reg <= |unf_v;
      overflow_reg  <= |ovf_v;
    end
  end

  assign underflow = underflow_reg;
  assign overflow  = overflow_reg;

`ifndef SYNTHESIS
  // Every pulse must trace back to a rejected request one cycle earlier.
  a_underflow_src: assert property (@(posedge clk) disable iff (!rst_n)
    underflow |-> $past(|unf_v));
  a_overflow_src: assert property (@(posedge clk) disable iff (!rst_n)
    overflow |-> $past(|ovf_v));
  c_underflow: cover property (@(posedge clk) underflow);
  c_overflow:  cover property (@(posedge clk) overflow);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chk
      a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        st[gi].count <= COUNT_W'(DEPTH));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_nx_fifo_mc.sv
// tb_nx_fifo_mc -- directed self-checking bench for nx_fifo_mc.
// Expected read data comes from per-channel scoreboard queues filled as
// writes are driven; occupancy and flags are derived from queue sizes.
// Build with +define+NX_FIFO_MC_PARITY_EN to include the parity steps.
module tb_nx_fifo_mc;
  localparam int N_CH      = 4;
  localparam int DEPTH     = 8;
  localparam int WIDTH     = 64;
  localparam int AFULL_LVL = 6;
  localparam int CW        = 2;
  localparam int UW        = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   empty;
  logic [N_CH-1:0]   full;
  logic [N_CH-1:0]   almost_full;
  logic [N_CH*UW-1:0] used_slots;
  logic              underflow;
  logic              overflow;

  always #5 clk = ~clk;

  nx_fifo_mc_if #(.CW(CW), .WIDTH(WIDTH)) bus ();

  nx_fifo_mc #(
    .N_CH       (N_CH),
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .AFULL_LVL  (AFULL_LVL),
    .DATA_RESET (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear       (clear),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .used_slots  (used_slots),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;

  logic [WIDTH-1:0] sb [N_CH][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    for (int c = 0; c < N_CH; c++) begin
      int n;
      n = sb[c].size();
      check($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(n == 0));
      check($sformatf("full[%0d]", c), 64'(full[c]), 64'(n == DEPTH));
      check($sformatf("almost_full[%0d]", c), 64'(almost_full[c]), 64'(n >= AFULL_LVL));
      check($sformatf("used_slots[%0d]", c), 64'(used_slots[c*UW +: UW]), 64'(n));
    end
  endtask

  // One clock of traffic: drive at posedge+1, check the FWFT head at
  // posedge+2, update the model, then check pulses/status after the edge.
  task automatic step(input logic w, input int wc, input logic [63:0] wd,
                      input logic r, input int rc, input logic [N_CH-1:0] clr,
                      input logic inj = 1'b0);
    int nr, nw;
    logic exp_unf, exp_ovf;
    logic [63:0] exp_rd;
    bus.wen   = w;
    bus.wch   = wc[CW-1:0];
    bus.wdata = wd;
    bus.ren   = r;
    bus.rch   = rc[CW-1:0];
    clear     = clr;
`ifdef NX_FIFO_MC_PARITY_EN
    bus.inj_perr = inj;
`endif
    #1;
    nr = sb[rc].size();
    nw = sb[wc].size();
    exp_rd = (nr > 0) ? sb[rc][0] : 64'h0;
    check($sformatf("rdata ch%0d", rc), bus.rdata, exp_rd);
    exp_unf = r && !clr[rc] && (nr == 0);
    exp_ovf = w && !clr[wc] && (nw == DEPTH);
    if (r && !clr[rc] && nr > 0) void'(sb[rc].pop_front());
    if (w && !clr[wc] && nw < DEPTH) sb[wc].push_back(wd);
    for (int c = 0; c < N_CH; c++) if (clr[c]) sb[c].delete();
    n_step++;
    $display("step %0d: wen=%0b wch=%0d wdata=0x%0h ren=%0b rch=%0d rdata=0x%0h clear=%b inj=%0b",
             n_step, w, wc, wd, r, rc, bus.rdata, clr, inj);
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    clear   = '0;
`ifdef NX_FIFO_MC_PARITY_EN
    bus.inj_perr = 1'b0;
`endif
    check("underflow", 64'(underflow), 64'(exp_unf));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check_status();
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = '0;
    bus.wen   = 1'b0;
    bus.wch   = '0;
    bus.wdata = '0;
    bus.ren   = 1'b0;
    bus.rch   = '0;
`ifdef NX_FIFO_MC_PARITY_EN
    bus.inj_perr = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset underflow", 64'(underflow), 64'h0);
    check("reset overflow", 64'(overflow), 64'h0);
    check_status();
    rst_n = 1'b1;

    // Fill ch2 to full; almost_full rises after the 6th write
    for (int i = 0; i < 8; i++) step(1'b1, 2, 64'hA0 + 64'(i), 1'b0, 2, '0);
    // Drain ch2 in order
    for (int i = 0; i < 8; i++) step(1'b0, 2, 64'h0, 1'b1, 2, '0);

    // Write ch0 while popping empty ch1 -> underflow; then peek ch0
    step(1'b1, 0, 64'h11, 1'b1, 1, '0);
    step(1'b0, 0, 64'h0, 1'b0, 0, '0);

    // ch3 full: simultaneous write+read -> oldest read, write rejected
    for (int i = 0; i < 8; i++) step(1'b1, 3, 64'h30 + 64'(i), 1'b0, 3, '0);
    step(1'b1, 3, 64'h3F, 1'b1, 3, '0);

    // Pointer wrap on ch1 with steady occupancy of 1
    step(1'b1, 1, 64'h100, 1'b0, 1, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1, 64'h101 + 64'(i), 1'b1, 1, '0);

    // ch0 to 5 entries, then clear with a simultaneous write, then pop
    for (int i = 0; i < 4; i++) step(1'b1, 0, 64'h12 + 64'(i), 1'b0, 0, '0);
    step(1'b1, 0, 64'hDEAD, 1'b0, 0, 4'b0001);
    step(1'b0, 0, 64'h0, 1'b1, 0, '0);

    // Reset in the middle of traffic, with a write in flight
    step(1'b1, 2, 64'h55, 1'b0, 2, '0);
    step(1'b1, 2, 64'h56, 1'b0, 2, '0);
    bus.wen   = 1'b1;
    bus.wch   = 2'd2;
    bus.wdata = 64'h57;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.wen = 1'b0;
    for (int c = 0; c < N_CH; c++) sb[c].delete();
    $display("step reset: rst_n=0 with wen=1 wch=2 wdata=0x57");
    check("midreset underflow", 64'(underflow), 64'h0);
    check("midreset overflow", 64'(overflow), 64'h0);
    check_status();
    step(1'b0, 0, 64'h0, 1'b0, 2, '0);

`ifdef NX_FIFO_MC_PARITY_EN
    // Corrupted parity is flagged while at the head; a clean entry is not
    step(1'b1, 0, 64'h3, 1'b0, 0, '0, 1'b1);
    bus.rch = 2'd0;
    #1;
    check("rdata_perr injected", 64'(bus.rdata_perr), 64'h1);
    step(1'b0, 0, 64'h0, 1'b1, 0, '0);
    step(1'b1, 0, 64'h5, 1'b0, 0, '0);
    bus.rch = 2'd0;
    #1;
    check("rdata_perr clean", 64'(bus.rdata_perr), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
